uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_bit_timer.sv | 52 +++++
 rtl/uart_tx.sv | 113 +++++++++++
 tb/tb_uart_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter slice.
//   state_e     : transmitter FSM states (IDLE, WAITING, SENDING)
//   FRAME_BITS  : serial bits per frame (start + 8 data + stop)
//   DATA_BITS   : payload width
//   build_frame : assembles the shift-register image {stop, data, start}
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = 8;

   // Bit counter spans 0..FRAME_BITS-1.
   localparam int                     BIT_CNT_W = 4;
   localparam logic [BIT_CNT_W-1:0]   LAST_BIT  = BIT_CNT_W'(FRAME_BITS - 1);

   // A shift register full of ones keeps the line at its idle (mark) level.
   localparam logic [FRAME_BITS-1:0]  LINE_IDLE = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAITING = 2'd1,
      SENDING = 2'd2
   } state_e;

   // Bit 0 goes out first: start bit (0), data LSB first, then stop bit (1).
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] data);
      return {1'b1, data, 1'b0};
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Counts CLKS_PER_BIT clock cycles per serial bit while enabled and pulses
// bit_done_o on the last cycle of each bit period.
//   clk_i      : clock, rising edge
//   reset_i    : asynchronous active-high reset
//   en_i       : count while high; counter is cleared while low
//   bit_done_o : high during the final cycle of a bit period
// -----------------------------------------------------------------------------
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic en_i,
   output logic bit_done_o
);

   // Keep at least one bit of counter so CLKS_PER_BIT = 1 still elaborates.
   localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      cnt_d      = cnt_q;
      bit_done_o = 1'b0;
      if (!en_i) begin
         // Cleared outside a frame so the first bit gets a full period.
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d      = '0;
         bit_done_o = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Single-byte UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit,
// each bit held for CLKS_PER_BIT clock cycles.
//   clk_i        : clock, rising edge
//   reset_i      : asynchronous active-high reset; aborts any frame at once
//   byte_ready_i : load strobe, captures data_in into the holding register
//                  (IDLE or WAITING)
//   t_byte_i     : transmit request, starts the frame for the held byte
//                  (WAITING only)
//   data_in      : parallel byte to transmit
//   Tx           : serial line, idle high, taken straight from a flop
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       byte_ready_i,
   input  logic       t_byte_i,
   input  logic [7:0] data_in,
   output logic       Tx
);

   state_e                   state_q,   state_d;
   logic [DATA_BITS-1:0]     hold_q,    hold_d;
   logic [FRAME_BITS-1:0]    shift_q,   shift_d;
   logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                     bit_done;

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .en_i       (state_q == SENDING),
      .bit_done_o (bit_done)
   );

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;

      case (state_q)
         IDLE: begin
            // t_byte_i is deliberately not looked at here, so a held or
            // unknown request cannot start or disturb anything.
            if (byte_ready_i) begin
               hold_d  = data_in;
               state_d = WAITING;
            end
         end

         WAITING: begin
            // A request wins over a simultaneous load: the byte already held
            // is sent and the new data_in is dropped.
            if (t_byte_i) begin
               shift_d   = build_frame(hold_q);
               bit_cnt_d = '0;
               state_d   = SENDING;
            end else if (byte_ready_i) begin
               hold_d = data_in;
            end
         end

         SENDING: begin
            if (bit_done) begin
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  shift_d   = LINE_IDLE;
                  state_d   = IDLE;
               end else begin
                  // Shift in ones so the line drifts towards idle.
                  shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end

         default: begin
            shift_d   = LINE_IDLE;
            bit_cnt_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         // NOTE: the holding and shift registers are ordinary flops, so they
         // take reset values like the rest; the all-ones shift image is what
         // drives Tx high the moment reset asserts.
         state_q   <= IDLE;
         hold_q    <= '0;
         shift_q   <= LINE_IDLE;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // Bit 0 of the shift register is the line itself: registered, and the
   // start bit appears on the same edge that enters SENDING.
   assign Tx = shift_q[0];

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Directed bench for uart_tx: one instance with CLKS_PER_BIT = 1 and one with
// CLKS_PER_BIT = 4. Inputs change on the falling edge; outputs are compared
// on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx;
   import uart_pkg::*;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       byte_ready;
   logic       t_byte;
   logic [7:0] data;
   logic       tx1;
   logic       byte_ready4;
   logic       t_byte4;
   logic [7:0] data4;
   logic       tx4;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk_i = ~clk_i;

   uart_tx #(.CLKS_PER_BIT(1)) dut1 (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .byte_ready_i (byte_ready),
      .t_byte_i     (t_byte),
      .data_in      (data),
      .Tx           (tx1)
   );

   uart_tx #(.CLKS_PER_BIT(4)) dut4 (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .byte_ready_i (byte_ready4),
      .t_byte_i     (t_byte4),
      .data_in      (data4),
      .Tx           (tx4)
   );

   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Checks the ten bit periods of a CLKS_PER_BIT = 1 frame on tx1; the first
   // falling edge sampled is the one right after the start edge.
   task automatic check_frame(input string tag, input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         check(tag, {7'b0, tx1}, {7'b0, f[i]});
      end
   endtask

   initial begin
      logic [9:0] f4;

      // ---------------- reset, with t_byte unknown ----------------
      reset_i     = 1'b1;
      byte_ready  = 1'b0;
      t_byte      = 1'bx;
      data        = 8'h00;
      byte_ready4 = 1'b0;
      t_byte4     = 1'b0;
      data4       = 8'h00;
      #2;
      check("reset_tx1",   {7'b0, tx1}, 8'h01);
      check("reset_tx4",   {7'b0, tx4}, 8'h01);
      check("reset_state", {6'b0, dut1.state_q}, {6'b0, IDLE});

      // ---------------- scenario 1: 0xAA, one clock per bit ----------------
      @(negedge clk_i);                      // t = 10
      check("reset_hold", dut1.hold_q, 8'h00);
      reset_i    = 1'b0;
      t_byte     = 1'b0;
      byte_ready = 1'b1;
      data       = 8'hAA;
      @(negedge clk_i);                      // t = 20, captured at 15
      check("s1_waiting_tx", {7'b0, tx1}, 8'h01);
      check("s1_waiting_state", {6'b0, dut1.state_q}, {6'b0, WAITING});
      byte_ready = 1'b0;
      t_byte     = 1'b1;
      check_frame("s1_frame_aa", 8'hAA);     // edges 25..115
      @(negedge clk_i);                      // t = 130, after edge 125
      check("s1_idle_tx", {7'b0, tx1}, 8'h01);
      check("s1_idle_state", {6'b0, dut1.state_q}, {6'b0, IDLE});

      // ---------------- scenario 5: held request does not retransmit --------
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_i);
         check("s5_no_retx", {7'b0, tx1}, 8'h01);
      end
      byte_ready = 1'b1;
      data       = 8'h5A;
      @(negedge clk_i);                      // captured; request seen next edge
      check("s5_capture_tx", {7'b0, tx1}, 8'h01);
      byte_ready = 1'b0;
      check_frame("s5_frame_5a", 8'h5A);
      @(negedge clk_i);
      check("s5_idle_tx", {7'b0, tx1}, 8'h01);

      // ---------------- unknown request in IDLE ----------------
      t_byte = 1'bx;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         check("x_req_idle_tx", {7'b0, tx1}, 8'h01);
      end
      check("x_req_idle_state", {6'b0, dut1.state_q}, {6'b0, IDLE});
      t_byte = 1'b0;

      // ------- scenario 3: latest byte wins; simultaneous load is dropped ----
      @(negedge clk_i);
      byte_ready = 1'b1;
      data       = 8'h3C;
      @(negedge clk_i);                      // 0x3C held, WAITING
      data       = 8'hC3;
      @(negedge clk_i);                      // 0xC3 recaptured
      data       = 8'h99;
      t_byte     = 1'b1;                     // load and request on same edge
      check_frame("s3_frame_c3", 8'hC3);
      @(negedge clk_i);                      // back in IDLE
      check("s3_idle_tx", {7'b0, tx1}, 8'h01);
      byte_ready = 1'b0;
      t_byte     = 1'b0;
      @(negedge clk_i);
      check("s3_idle_state", {6'b0, dut1.state_q}, {6'b0, IDLE});

      // ---------------- scenario 4: reset at data bit 3 ----------------
      byte_ready = 1'b1;
      data       = 8'h00;
      @(negedge clk_i);
      byte_ready = 1'b0;
      t_byte     = 1'b1;
      for (int i = 0; i < 5; i++) begin      // start bit, data bits 0..3
         @(negedge clk_i);
         check("s4_low_bits", {7'b0, tx1}, 8'h00);
      end
      #2;
      reset_i = 1'b1;
      t_byte  = 1'bx;
      #1;                                    // still before the next rising edge
      check("s4_async_tx", {7'b0, tx1}, 8'h01);
      check("s4_async_state", {6'b0, dut1.state_q}, {6'b0, IDLE});
      @(negedge clk_i);
      check("s4_in_reset_tx", {7'b0, tx1}, 8'h01);
      reset_i = 1'b0;
      t_byte  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         check("s4_no_frame", {7'b0, tx1}, 8'h01);
      end
      t_byte = 1'b0;

      // First capture after reset on the first edge with byte_ready high.
      @(negedge clk_i);
      byte_ready = 1'b1;
      data       = 8'h81;
      @(negedge clk_i);
      check("s4_recover_state", {6'b0, dut1.state_q}, {6'b0, WAITING});
      byte_ready = 1'b0;
      t_byte     = 1'b1;
      check_frame("s4_frame_81", 8'h81);
      @(negedge clk_i);
      t_byte = 1'b0;
      check("s4_idle_tx", {7'b0, tx1}, 8'h01);

      // ---------------- scenario 2: 0x01, four clocks per bit ----------------
      f4          = {1'b1, 8'h01, 1'b0};
      byte_ready4 = 1'b1;
      data4       = 8'h01;
      @(negedge clk_i);
      byte_ready4 = 1'b0;
      t_byte4     = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_i);
         check("s2_frame_cycle", {7'b0, tx4}, {7'b0, f4[c / 4]});
      end
      // The edge after the 40th cycle must already be in IDLE, so a load
      // presented for that edge is taken and the held request starts a frame
      // on the one after.
      @(negedge clk_i);
      byte_ready4 = 1'b1;
      data4       = 8'h00;
      @(negedge clk_i);
      byte_ready4 = 1'b0;
      check("s2_reload_tx", {7'b0, tx4}, 8'h01);
      @(negedge clk_i);
      check("s2_next_start", {7'b0, tx4}, 8'h00);
      t_byte4 = 1'b0;
      repeat (40) @(negedge clk_i);
      check("s2_final_tx", {7'b0, tx4}, 8'h01);
      check("s2_final_state", {6'b0, dut4.state_q}, {6'b0, IDLE});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
